// File: rtl/axi_write_arbiter.sv
// rtl/axi_write_arbiter.sv - two-master round-robin AXI write arbiter, one burst outstanding
module axi_write_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ADDR_W-1:0] m0_AWADDR,
    input  logic [7:0]        m0_AWLEN,
    input  logic              m0_AWVALID,
    output logic              m0_AWREADY,
    input  logic [DATA_W-1:0] m0_WDATA,
    input  logic              m0_WVALID,
    input  logic              m0_WLAST,
    output logic              m0_WREADY,
    output logic [1:0]        m0_BRESP,
    output logic              m0_BVALID,
    input  logic [ADDR_W-1:0] m1_AWADDR,
    input  logic [7:0]        m1_AWLEN,
    input  logic              m1_AWVALID,
    output logic              m1_AWREADY,
    input  logic [DATA_W-1:0] m1_WDATA,
    input  logic              m1_WVALID,
    input  logic              m1_WLAST,
    output logic              m1_WREADY,
    output logic [1:0]        m1_BRESP,
    output logic              m1_BVALID,
    output logic [ADDR_W-1:0] s_AWADDR,
    output logic [7:0]        s_AWLEN,
    output logic              s_AWVALID,
    input  logic              s_AWREADY,
    output logic [DATA_W-1:0] s_WDATA,
    output logic              s_WVALID,
    output logic              s_WLAST,
    input  logic              s_WREADY,
    input  logic [1:0]        s_BRESP,
    input  logic              s_BVALID,
    output logic [1:0]        grant,
    output logic              busy,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t      state, state_nx;
    logic        last_grant;     // 1 = m1 was served last
    logic [8:0]  beat_cnt;
    logic [7:0]  len_q;
    logic        err_flag;

    logic              sel1;
    logic              g_awvalid, g_wvalid, g_wlast;
    logic [ADDR_W-1:0] g_awaddr;
    logic [7:0]        g_awlen;
    logic [DATA_W-1:0] g_wdata;
    logic              aw_hs, w_hs, at_last, pick1;
    logic [9:0]        beat_num, last_num;
    logic [1:0]        b_resp;

    assign sel1      = grant[1];
    assign g_awvalid = sel1 ? m1_AWVALID : m0_AWVALID;
    assign g_awaddr  = sel1 ? m1_AWADDR  : m0_AWADDR;
    assign g_awlen   = sel1 ? m1_AWLEN   : m0_AWLEN;
    assign g_wvalid  = sel1 ? m1_WVALID  : m0_WVALID;
    assign g_wlast   = sel1 ? m1_WLAST   : m0_WLAST;
    assign g_wdata   = sel1 ? m1_WDATA   : m0_WDATA;

    assign aw_hs    = (state == ADDR) && g_awvalid && s_AWREADY;
    assign w_hs     = (state == DATA) && g_wvalid && s_WREADY;
    assign beat_num = {1'b0, beat_cnt} + 10'd1;
    assign last_num = {2'b00, len_q} + 10'd1;
    assign at_last  = (beat_num == last_num);
    assign b_resp   = err_flag ? 2'b10 : s_BRESP;
    // On a tie the master not served last wins; a lone requester always wins.
    assign pick1    = m1_AWVALID && (!m0_AWVALID || !last_grant);
    assign busy     = (state != IDLE);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        s_AWADDR   = '0;
        s_AWLEN    = '0;
        s_AWVALID  = 1'b0;
        s_WDATA    = '0;
        s_WVALID   = 1'b0;
        s_WLAST    = 1'b0;
        m0_AWREADY = 1'b0;
        m1_AWREADY = 1'b0;
        m0_WREADY  = 1'b0;
        m1_WREADY  = 1'b0;
        m0_BVALID  = 1'b0;
        m1_BVALID  = 1'b0;
        m0_BRESP   = 2'b00;
        m1_BRESP   = 2'b00;
        case (state)
            IDLE: if (m0_AWVALID || m1_AWVALID) state_nx = ADDR;
            ADDR: begin
                s_AWADDR   = g_awaddr;
                s_AWLEN    = g_awlen;
                s_AWVALID  = g_awvalid;
                m0_AWREADY = grant[0] && s_AWREADY;
                m1_AWREADY = grant[1] && s_AWREADY;
                if (aw_hs) state_nx = DATA;
            end
            DATA: begin
                s_WDATA   = g_wdata;
                s_WVALID  = g_wvalid;
                s_WLAST   = g_wlast;
                m0_WREADY = grant[0] && s_WREADY;
                m1_WREADY = grant[1] && s_WREADY;
                if (w_hs && g_wlast) state_nx = RESP;
            end
            RESP: if (s_BVALID) begin
                m0_BVALID = grant[0];
                m1_BVALID = grant[1];
                m0_BRESP  = grant[0] ? b_resp : 2'b00;
                m1_BRESP  = grant[1] ? b_resp : 2'b00;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            grant      <= 2'b00;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            len_q      <= '0;
            err_flag   <= 1'b0;
            err_count  <= '0;
        end else begin
            case (state)
                IDLE: if (m0_AWVALID || m1_AWVALID) grant <= pick1 ? 2'b10 : 2'b01;
                ADDR: if (aw_hs) begin
                    beat_cnt <= '0;
                    len_q    <= g_awlen;
                end
                DATA: if (w_hs) begin
                    if (beat_cnt != 9'd511) beat_cnt <= beat_cnt + 9'd1;
                    // Early WLAST, or the final beat arriving without WLAST.
                    if (g_wlast != at_last) err_flag <= 1'b1;
                end
                RESP: if (s_BVALID) begin
                    last_grant <= grant[1];
                    grant      <= 2'b00;
                    err_flag   <= 1'b0;
                    if (err_flag && err_count != 8'hFF) err_count <= err_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// tb/tb_axi_write_arbiter.sv - randomized self-checking bench for axi_write_arbiter
module tb_axi_write_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic ACLK = 1'b0;
    logic ARESET;
    always #5 ACLK = ~ACLK;

    logic [AW-1:0] awaddr [2];
    logic [7:0]    awlen  [2];
    logic          awvalid[2];
    logic [DW-1:0] wdata  [2];
    logic          wvalid [2];
    logic          wlast  [2];

    logic m0_AWREADY, m1_AWREADY, m0_WREADY, m1_WREADY, m0_BVALID, m1_BVALID;
    logic [1:0] m0_BRESP, m1_BRESP;
    logic [AW-1:0] s_AWADDR;
    logic [7:0]    s_AWLEN;
    logic          s_AWVALID, s_AWREADY;
    logic [DW-1:0] s_WDATA;
    logic          s_WVALID, s_WLAST, s_WREADY;
    logic [1:0]    s_BRESP;
    logic          s_BVALID;
    logic [1:0]    grant;
    logic          busy;
    logic [7:0]    err_count;

    logic [1:0] awready_v, wready_v, bvalid_v;
    logic [3:0] bresp_v;
    assign awready_v = {m1_AWREADY, m0_AWREADY};
    assign wready_v  = {m1_WREADY, m0_WREADY};
    assign bvalid_v  = {m1_BVALID, m0_BVALID};
    assign bresp_v   = {m1_BRESP, m0_BRESP};

    axi_write_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .m0_AWADDR(awaddr[0]), .m0_AWLEN(awlen[0]), .m0_AWVALID(awvalid[0]), .m0_AWREADY(m0_AWREADY),
        .m0_WDATA(wdata[0]), .m0_WVALID(wvalid[0]), .m0_WLAST(wlast[0]), .m0_WREADY(m0_WREADY),
        .m0_BRESP(m0_BRESP), .m0_BVALID(m0_BVALID),
        .m1_AWADDR(awaddr[1]), .m1_AWLEN(awlen[1]), .m1_AWVALID(awvalid[1]), .m1_AWREADY(m1_AWREADY),
        .m1_WDATA(wdata[1]), .m1_WVALID(wvalid[1]), .m1_WLAST(wlast[1]), .m1_WREADY(m1_WREADY),
        .m1_BRESP(m1_BRESP), .m1_BVALID(m1_BVALID),
        .s_AWADDR(s_AWADDR), .s_AWLEN(s_AWLEN), .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY),
        .s_WDATA(s_WDATA), .s_WVALID(s_WVALID), .s_WLAST(s_WLAST), .s_WREADY(s_WREADY),
        .s_BRESP(s_BRESP), .s_BVALID(s_BVALID),
        .grant(grant), .busy(busy), .err_count(err_count)
    );

    int checks = 0;
    int passes = 0;
    int viol = 0;
    int phase[2];
    int beat[2];
    int wlast_at[2];
    int fwd;
    bit b_pending;
    int b_delay;
    int bresp_mode;
    logic [1:0] prev_grant;
    int exp_ec;
    int rr_last;

    int         done_m[$];
    logic [1:0] done_resp[$];
    int         done_beats[$];
    logic [1:0] sent_q[$];
    logic [1:0] grant_q[$];

    task automatic clear_queues();
        done_m.delete(); done_resp.delete(); done_beats.delete();
        sent_q.delete(); grant_q.delete();
    endtask

    task automatic clear_bench();
        for (int i = 0; i < 2; i++) begin
            awaddr[i] = '0; awlen[i] = '0; awvalid[i] = 1'b0;
            wdata[i] = '0; wvalid[i] = 1'b0; wlast[i] = 1'b0;
            phase[i] = 0; beat[i] = 0; wlast_at[i] = 1;
        end
        s_AWREADY = 1'b0; s_WREADY = 1'b0; s_BVALID = 1'b0; s_BRESP = 2'b00;
        b_pending = 1'b0; b_delay = 0; fwd = 0; prev_grant = 2'b00;
        clear_queues();
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        clear_bench();
        repeat (2) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        exp_ec = 0;
        rr_last = 1;
    endtask

    task automatic request(input int i, input int len, input int wl);
        awaddr[i]  = $urandom;
        awlen[i]   = 8'(len);
        awvalid[i] = 1'b1;
        phase[i]   = 1;
        beat[i]    = 0;
        wlast_at[i] = wl;
    endtask

    // One clock: observe at negedge, then drive master/slave behaviour after the edge.
    task automatic cycle();
        logic [1:0] aw_hs, w_hs;
        logic s_w_hs, blast;
        int own;
        @(negedge ACLK);
        own = grant[1] ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
            aw_hs[i] = awvalid[i] & awready_v[i];
            w_hs[i]  = wvalid[i] & wready_v[i];
            if (!grant[i] && (awready_v[i] || wready_v[i] || bvalid_v[i] || bresp_v[2*i +: 2] != 2'b00))
                viol++;
        end
        if ($countones(grant) > 1 || busy != (grant != 2'b00)) viol++;
        if ((s_AWVALID || s_WVALID) && grant == 2'b00) viol++;
        if (s_AWVALID && s_AWREADY && (s_AWADDR !== awaddr[own] || s_AWLEN !== awlen[own] || !aw_hs[own]))
            viol++;
        if (s_WVALID && (s_WDATA !== wdata[own] || s_WLAST !== wlast[own])) viol++;
        s_w_hs = s_WVALID & s_WREADY;
        if (s_w_hs) fwd++;
        blast = s_w_hs & s_WLAST;
        if (grant != 2'b00 && prev_grant == 2'b00) grant_q.push_back(grant);
        prev_grant = grant;
        for (int i = 0; i < 2; i++) begin
            if (bvalid_v[i]) begin
                done_m.push_back(i);
                done_resp.push_back(bresp_v[2*i +: 2]);
                done_beats.push_back(fwd);
                fwd = 0;
                phase[i] = 0;
            end
        end
        @(posedge ACLK);
        #1;
        s_BVALID = 1'b0;
        if (blast) begin
            b_pending = 1'b1;
            b_delay = $urandom_range(0, 3);
        end
        if (b_pending) begin
            if (b_delay == 0) begin
                s_BVALID = 1'b1;
                s_BRESP = (bresp_mode != 0) ? 2'($urandom_range(0, 1)) : 2'b00;
                sent_q.push_back(s_BRESP);
                b_pending = 1'b0;
            end else begin
                b_delay--;
            end
        end
        s_AWREADY = 1'($urandom_range(0, 1));
        s_WREADY  = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 2; i++) begin
            if (aw_hs[i]) begin
                awvalid[i] = 1'b0;
                phase[i] = 2;
                beat[i] = 0;
            end
            if (w_hs[i]) begin
                beat[i]++;
                wvalid[i] = 1'b0;
                wlast[i] = 1'b0;
                if (beat[i] == wlast_at[i]) phase[i] = 3;
            end
            if (phase[i] == 2 && !wvalid[i] && $urandom_range(0, 3) != 0) begin
                wvalid[i] = 1'b1;
                wdata[i] = $urandom;
                wlast[i] = (beat[i] + 1 == wlast_at[i]);
            end
        end
    endtask

    task automatic run(input int n, input int budget);
        int c = 0;
        while (done_m.size() < n && c < budget) begin
            cycle();
            c++;
        end
        checks++;
        if (done_m.size() < n) $display("FAIL run_timeout: got %0d responses, expected %0d", done_m.size(), n);
        else passes++;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        clear_bench();
        awvalid[0] = 1'b1; awvalid[1] = 1'b1; s_AWREADY = 1'b1; s_WREADY = 1'b1;
        @(negedge ACLK);
        checks++;
        if (grant !== 2'b00) $display("FAIL reset_grant: got %b expected 00", grant); else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++;
        if (err_count !== 8'd0) $display("FAIL reset_err_count: got %0d expected 0", err_count); else passes++;
        checks++;
        if ({m0_AWREADY, m1_AWREADY, s_AWVALID, s_WVALID, m0_BVALID, m1_BVALID, s_AWADDR} !== '0)
            $display("FAIL reset_outputs: got awr=%b%b sav=%b swv=%b addr=%h expected all 0",
                     m0_AWREADY, m1_AWREADY, s_AWVALID, s_WVALID, s_AWADDR);
        else passes++;
        do_reset();
    endtask

    task automatic test_single_burst();
        do_reset();
        bresp_mode = 0;
        viol = 0;
        request(0, 3, 4);
        @(negedge ACLK);
        checks++;
        if (s_AWVALID !== 1'b0) $display("FAIL aw_latency_pre: got s_AWVALID=%b expected 0", s_AWVALID); else passes++;
        @(posedge ACLK);
        @(negedge ACLK);
        checks++;
        if ({s_AWVALID, grant} !== 3'b101)
            $display("FAIL aw_latency: got s_AWVALID=%b grant=%b expected 1/01", s_AWVALID, grant);
        else passes++;
        run(1, 200);
        if (done_m.size() >= 1) begin
            checks++;
            if (done_m[0] != 0 || done_beats[0] != 4 || done_resp[0] !== 2'b00)
                $display("FAIL single_burst: got m%0d beats=%0d resp=%b expected m0 beats=4 resp=00",
                         done_m[0], done_beats[0], done_resp[0]);
            else passes++;
        end
        checks++;
        if (err_count !== 8'd0) $display("FAIL single_err_count: got %0d expected 0", err_count); else passes++;
        checks++;
        if (viol != 0) $display("FAIL single_protocol: got %0d violations expected 0", viol); else passes++;
    endtask

    task automatic test_round_robin();
        int l0, l1;
        do_reset();
        bresp_mode = 1;
        viol = 0;
        for (int r = 0; r < 2; r++) begin
            l0 = $urandom_range(0, 3);
            l1 = $urandom_range(0, 3);
            request(0, l0, l0 + 1);
            request(1, l1, l1 + 1);
            run(2 * (r + 1), 400);
        end
        checks++;
        if (done_m.size() != 4 || done_m[0] != 0 || done_m[1] != 1 || done_m[2] != 0 || done_m[3] != 1)
            $display("FAIL rr_order: got %0d responses, first=%0d expected order 0,1,0,1",
                     done_m.size(), done_m.size() > 0 ? done_m[0] : -1);
        else passes++;
        checks++;
        if (grant_q.size() < 3 || grant_q[0] !== 2'b01 || grant_q[1] !== 2'b10 || grant_q[2] !== 2'b01)
            $display("FAIL rr_grant_seq: got %0d grants expected 01,10,01", grant_q.size());
        else passes++;
        for (int k = 0; k < done_resp.size() && k < sent_q.size(); k++) begin
            checks++;
            if (done_resp[k] !== sent_q[k])
                $display("FAIL rr_bresp: burst %0d got %b expected %b", k, done_resp[k], sent_q[k]);
            else passes++;
        end
        checks++;
        if (viol != 0) $display("FAIL rr_protocol: got %0d violations expected 0", viol); else passes++;
    endtask

    task automatic test_short_wlast();
        do_reset();
        bresp_mode = 0;
        request(1, 3, 2);
        run(1, 200);
        exp_ec = 1;
        if (done_m.size() >= 1) begin
            checks++;
            if (done_m[0] != 1 || done_beats[0] != 2 || done_resp[0] !== 2'b10)
                $display("FAIL short_wlast: got m%0d beats=%0d resp=%b expected m1 beats=2 resp=10",
                         done_m[0], done_beats[0], done_resp[0]);
            else passes++;
        end
        checks++;
        if (err_count !== 8'(exp_ec)) $display("FAIL short_err_count: got %0d expected %0d", err_count, exp_ec);
        else passes++;
    endtask

    task automatic test_long_wlast();
        clear_queues();
        request(0, 1, 3);
        run(1, 200);
        exp_ec++;
        if (done_m.size() >= 1) begin
            checks++;
            if (done_m[0] != 0 || done_beats[0] != 3 || done_resp[0] !== 2'b10)
                $display("FAIL long_wlast: got m%0d beats=%0d resp=%b expected m0 beats=3 resp=10",
                         done_m[0], done_beats[0], done_resp[0]);
            else passes++;
        end
        checks++;
        if (err_count !== 8'(exp_ec)) $display("FAIL long_err_count: got %0d expected %0d", err_count, exp_ec);
        else passes++;
    endtask

    task automatic test_reset_mid_burst();
        int c = 0;
        clear_queues();
        bresp_mode = 1;
        request(0, 3, 4);
        fwd = 0;
        while (fwd < 1 && c < 200) begin
            cycle();
            c++;
        end
        checks++;
        if (fwd < 1) $display("FAIL mid_reach_beat2: got %0d beats expected 1", fwd); else passes++;
        ARESET = 1'b1;
        @(negedge ACLK);
        checks++;
        if ({grant, busy, s_WVALID, m0_BVALID, m1_BVALID} !== 6'b0)
            $display("FAIL mid_reset_state: got grant=%b busy=%b swv=%b bv=%b%b expected all 0",
                     grant, busy, s_WVALID, m1_BVALID, m0_BVALID);
        else passes++;
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        clear_bench();
        exp_ec = 0;
        rr_last = 1;
        viol = 0;
        request(1, 2, 3);
        run(1, 200);
        repeat (4) cycle();
        rr_last = 1;
        checks++;
        if (done_m.size() != 1 || done_m[0] != 1 || done_beats[0] != 3 || sent_q.size() != 1 ||
            done_resp[0] !== sent_q[0])
            $display("FAIL mid_followup: got %0d responses expected one m1 response with 3 beats", done_m.size());
        else passes++;
        checks++;
        if (err_count !== 8'd0) $display("FAIL mid_err_count: got %0d expected 0", err_count); else passes++;
        checks++;
        if (viol != 0) $display("FAIL mid_protocol: got %0d violations expected 0", viol); else passes++;
    endtask

    task automatic test_random();
        int mask, first, len[2], wl[2], order[$], base;
        viol = 0;
        bresp_mode = 1;
        for (int r = 0; r < 30; r++) begin
            clear_queues();
            mask = $urandom_range(1, 3);
            order.delete();
            for (int i = 0; i < 2; i++) begin
                len[i] = $urandom_range(0, 7);
                wl[i] = len[i] + 1;
                if ($urandom_range(0, 2) == 0) begin
                    wl[i] = $urandom_range(1, len[i] + 3);
                    if (wl[i] == len[i] + 1) wl[i] = len[i] + 2;
                end
                if (mask[i]) request(i, len[i], wl[i]);
            end
            if (mask == 3) begin
                first = (rr_last == 1) ? 0 : 1;
                order.push_back(first);
                order.push_back(1 - first);
            end else begin
                order.push_back(mask == 1 ? 0 : 1);
            end
            rr_last = order[$];
            base = order.size();
            run(base, 600);
            for (int k = 0; k < base && k < done_m.size() && k < sent_q.size(); k++) begin
                checks++;
                if (done_m[k] != order[k] || done_beats[k] != wl[order[k]] ||
                    done_resp[k] !== ((wl[order[k]] != len[order[k]] + 1) ? 2'b10 : sent_q[k]))
                    $display("FAIL random_burst: round %0d burst %0d got m%0d beats=%0d resp=%b expected m%0d beats=%0d",
                             r, k, done_m[k], done_beats[k], done_resp[k], order[k], wl[order[k]]);
                else passes++;
                if (wl[order[k]] != len[order[k]] + 1 && exp_ec < 255) exp_ec++;
            end
        end
        checks++;
        if (err_count !== 8'(exp_ec)) $display("FAIL random_err_count: got %0d expected %0d", err_count, exp_ec);
        else passes++;
        checks++;
        if (viol != 0) $display("FAIL random_protocol: got %0d violations expected 0", viol); else passes++;
    endtask

    task automatic test_saturate();
        do_reset();
        bresp_mode = 0;
        viol = 0;
        for (int b = 1; b <= 256; b++) begin
            clear_queues();
            request(b % 2, 0, 2);
            run(1, 100);
            if (b == 255) begin
                checks++;
                if (err_count !== 8'd255) $display("FAIL sat_at_255: got %0d expected 255", err_count); else passes++;
            end
        end
        checks++;
        if (err_count !== 8'd255) $display("FAIL sat_hold: got %0d expected 255", err_count); else passes++;
        checks++;
        if (viol != 0) $display("FAIL sat_protocol: got %0d violations expected 0", viol); else passes++;
    endtask

    initial begin
        ARESET = 1'b1;
        bresp_mode = 0;
        exp_ec = 0;
        rr_last = 1;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_short_wlast();
        test_long_wlast();
        test_reset_mid_burst();
        test_random();
        test_saturate();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/axi_write_arbiter.md
AXI_WRITE_ARBITER -- requirements
Module: axi_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI write-data width.
REQ-003 SHALL have port ACLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port ARESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports m0_AWADDR/m1_AWADDR  input  ADDR_W  requester write address.
REQ-006 SHALL have ports m0_AWLEN/m1_AWLEN  input  8  requester burst length minus one.
REQ-007 SHALL have ports m0_AWVALID/m1_AWVALID  input  1, and m0_AWREADY/m1_AWREADY  output  1, for the requester AW handshake.
REQ-008 SHALL have ports m0_WDATA/m1_WDATA  input  DATA_W, m0_WVALID/m1_WVALID  input  1, and m0_WLAST/m1_WLAST  input  1, for requester write beats.
REQ-009 SHALL have ports m0_WREADY/m1_WREADY  output  1  requester write-beat ready.
REQ-010 SHALL have ports m0_BRESP/m1_BRESP  output  2, and m0_BVALID/m1_BVALID  output  1, for the requester response; BVALID is a one-cycle pulse with no BREADY.
REQ-011 SHALL have ports s_AWADDR  output  ADDR_W, s_AWLEN  output  8, s_AWVALID  output  1, and s_AWREADY  input  1, to the memory slave.
REQ-012 SHALL have ports s_WDATA  output  DATA_W, s_WVALID  output  1, s_WLAST  output  1, and s_WREADY  input  1, to the memory slave.
REQ-013 SHALL have ports s_BRESP  input  2 and s_BVALID  input  1, slave response; s_BVALID is a one-cycle pulse.
REQ-014 SHALL have ports grant  output  2  one-hot current owner (00 = none), busy  output  1  state != IDLE, and err_count  output  8  saturating protocol-error count.

Function
REQ-015 SHALL implement FSM states IDLE, ADDR, DATA, RESP; exactly one burst outstanding at a time.
REQ-016 IDLE: when any mX_AWVALID=1, SHALL register grant and move to ADDR next cycle; s_AWVALID first asserts 1 cycle after the request is sampled.
REQ-017 Arbitration SHALL be round-robin: with both requesting, grant the master not granted last; a single requester always wins; last_grant resets to m1 so m0 wins the first tie.
REQ-018 ADDR: SHALL drive s_AWADDR/s_AWLEN from the granted master, s_AWVALID = granted mX_AWVALID, granted mX_AWREADY = s_AWREADY; on handshake, load beat counter with 0 and latch AWLEN, go to DATA.
REQ-019 DATA: SHALL route granted WDATA/WVALID/WLAST to the slave and s_WREADY to the granted WREADY; the beat counter (9 bits) increments on each s_WVALID&&s_WREADY.
REQ-020 On a W handshake with WLAST=1, SHALL go to RESP; if that beat is not beat AWLEN+1, SHALL set the burst error flag.
REQ-021 A handshake on beat AWLEN+1 without WLAST SHALL set the burst error flag; the burst continues until WLAST; the counter saturates at 511.
REQ-022 RESP: on s_BVALID, SHALL pulse granted mX_BVALID for 1 cycle with BRESP = s_BRESP, or 2'b10 (SLVERR) if the burst error flag is set.
REQ-023 On leaving RESP, SHALL update last_grant, clear grant and the error flag, increment err_count (saturating at 255) if the flag was set, and return to IDLE.
REQ-024 Non-granted masters SHALL see AWREADY=0, WREADY=0, BVALID=0, BRESP=00 at all times.
REQ-025 Outside ADDR, s_AWVALID SHALL be 0; outside DATA, s_WVALID and s_WLAST SHALL be 0.
REQ-026 New requests arriving in ADDR, DATA or RESP SHALL be held off (AWREADY=0) and arbitrated in the next IDLE.

Reset
REQ-027 While ARESET=1, SHALL force: state IDLE, grant=00, busy=0, err_count=0, last_grant=m1, counter 0, and all VALID/READY outputs, BRESP and s_AWADDR/s_AWLEN/s_WDATA at 0.
REQ-028 Reset asserted mid-burst SHALL abandon the burst immediately, with no B pulse issued to any master.

Verification
REQ-029 m0 only, AWLEN=3, 4 beats with WLAST on beat 4, s_BRESP=00 -> s_AWVALID 1 cycle after request, 4 slave beats, m0_BVALID pulse with BRESP=00, err_count=0.
REQ-030 m0 and m1 request in the same cycle after reset -> m0 served first, then m1; a second tie is granted to m0 again; grant goes 01 -> 10 -> 01.
REQ-031 m1 AWLEN=3 with WLAST on beat 2 -> m1_BRESP=10 and err_count=1.
REQ-032 m0 AWLEN=1 with WLAST only on beat 3 -> 3 beats forwarded, m0_BRESP=10, and err_count increments.
REQ-033 ARESET pulsed during DATA beat 2 -> next cycle grant=00, busy=0, s_WVALID=0, no BVALID; a following m1 request completes normally.
REQ-034 256 consecutive error bursts -> err_count holds at 255.
